dda_segment_gen: RTL and testbench
==================================

DDA_SEGMENT_GEN -- requirements
Module: dda_segment_gen

Interface
REQ-001 SHALL have parameter AXES, default 4, number of axes.
REQ-002 SHALL have parameter NW, default 10, command width per axis: bit NW-1 = direction, bits NW-2:0 = magnitude.
REQ-003 SHALL have parameter NMAX, default 50, pulse slots per segment.
REQ-004 SHALL have parameter HALF_DIV, default 200, clk cycles per half-slot.
REQ-005 SHALL have parameter PW, default 32, position counter width.
REQ-006 SHALL have port clk, input, 1 bit, sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port cmd, input, AXES*NW bits, per-axis command; axis i occupies bits [i*NW +: NW].
REQ-009 SHALL have port cmd_valid, input, 1 bit, command offered.
REQ-010 SHALL have port cmd_ready, output, 1 bit, command can be accepted.
REQ-011 SHALL have port abort, input, 1 bit, synchronous stop and flush.
REQ-012 SHALL have port pos_clr, input, 1 bit, synchronous clear of all position counters.
REQ-013 SHALL have port pulse, output, AXES bits, step pulses.
REQ-014 SHALL have port dir, output, AXES bits, direction; 1 = negative.
REQ-015 SHALL have port pos, output, AXES*PW bits, signed per-axis position.
REQ-016 SHALL have port busy, output, 1 bit, segment active.
REQ-017 SHALL have port seg_done, output, 1 bit, one-cycle end-of-segment strobe.
REQ-018 SHALL have port underrun, output, 1 bit, one-cycle strobe when a segment ends with no successor.

Function
REQ-019 SHALL accept a command on any edge where cmd_valid=1 and cmd_ready=1; cmd_ready = !shadow_full && !abort.
REQ-020 SHALL hold one active segment plus a one-deep shadow buffer.
REQ-021 SHALL, on acceptance in IDLE or at a segment-end edge with an empty shadow, load the command directly as the active segment; otherwise it goes to the shadow.
REQ-022 SHALL clamp each magnitude above NMAX to NMAX.
REQ-023 SHALL implement states IDLE, SETUP and RUN.
REQ-024 IDLE -> SETUP on segment load; at that edge dir updates, per-axis accumulators = NMAX-1, and busy = 1.
REQ-025 SETUP SHALL last one half-slot (HALF_DIV clocks) with all pulse bits 0; this is direction setup time.
REQ-026 RUN SHALL last NMAX slots of 2*HALF_DIV clocks each, so a segment lasts (2*NMAX+1)*HALF_DIV clocks.
REQ-027 At each slot start, per axis: acc += mag; if acc >= NMAX then acc -= NMAX and pulse = 1 for HALF_DIV clocks; else pulse = 0. The second half of every slot SHALL have pulse = 0.
REQ-028 Accumulator width SHALL be sufficient for 2*NMAX with no overflow; exactly mag pulses are emitted per segment.
REQ-029 At the edge ending the last slot, seg_done = 1 for one cycle.
  - If a successor exists (shadow or simultaneous acceptance): load it, enter SETUP, busy stays 1, no idle cycle.
  - Otherwise: IDLE, busy = 0, underrun = 1 for one cycle.
REQ-030 pos[i] SHALL change by +1 (dir=0) or -1 (dir=1) on the same edge pulse[i] rises, with two's-complement wrap.
REQ-031 pos_clr SHALL set all pos to 0 and take priority over a simultaneous pulse increment.
REQ-032 abort SHALL, on the next edge:
  - force pulse = 0, clear the shadow and state (IDLE), busy = 0;
  - emit no seg_done and no underrun;
  - drop any concurrently offered command;
  - leave pos and dir unchanged.
REQ-033 A magnitude of 0 SHALL still run a full-length segment with no pulses.

Reset
REQ-034 rst_n = 0 SHALL immediately force state IDLE, shadow empty, pulse = 0, dir = 0, pos = 0, busy = 0, seg_done = 0, underrun = 0, accumulators = 0, prescaler = 0; cmd_ready = 1.
REQ-035 Reset release SHALL need no further initialisation; the first accepted command starts SETUP.

Verification (AXES=2, NMAX=5, HALF_DIV=2)
REQ-036 Send axis0 mag=5, dir=0 and axis1 mag=2 -> axis0 emits 5 pulses of 2 clocks each, one per slot; axis1 pulses only in slots 0 and 2; busy is 1 for 22 clocks; pos0=+5, pos1=+2; one seg_done; one underrun.
REQ-037 Queue back-to-back axis0 mag=5 dir=0, then mag=3 dir=1 -> busy never drops; dir0 switches at the boundary edge; SETUP gap is 2 clocks; final pos0=+2; underrun only after the second segment.
REQ-038 Hold cmd_valid with the shadow full -> cmd_ready = 0 until the segment-end edge; the command is accepted in the next cycle; no command is lost or duplicated.
REQ-039 Assert abort in slot 2 -> pulse = 0 and busy = 0 next edge; shadow flushed; pos retains the pulses already counted; no seg_done.
REQ-040 Send mag=7 -> clamped to exactly 5 pulses; send mag=0 -> 22-clock segment with no pulses.
REQ-041 Drop rst_n mid-pulse -> pulse, busy and pos are 0 before the next clk edge; cmd_ready = 1.

Source files
------------

// File: rtl/dda_segment_gen.sv
// Multi-axis DDA step generator: one active segment plus a one-deep shadow,
// each segment is a setup half-slot followed by NMAX pulse slots.
//
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
// are both 1; cmd_ready depends only on shadow occupancy and abort.
module dda_segment_gen #(
   parameter int AXES     = 4,
   parameter int NW       = 10,
   parameter int NMAX     = 50,
   parameter int HALF_DIV = 200,
   parameter int PW       = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [AXES*NW-1:0]   cmd,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 abort,
   input  logic                 pos_clr,
   output logic [AXES-1:0]      pulse,
   output logic [AXES-1:0]      dir,
   output logic [AXES*PW-1:0]   pos,
   output logic                 busy,
   output logic                 seg_done,
   output logic                 underrun,
   output logic [1:0]           dbg_state
);
   localparam int MW = NW - 1;
   localparam int AW = $clog2(2*NMAX + 1);
   localparam int HW = $clog2(2*NMAX + 1);
   localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [AW-1:0] NMAX_A = AW'(NMAX);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, RUN = 2'd2} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      presc;
   logic [HW-1:0]      half;
   logic [AW-1:0]      acc     [AXES];
   logic [AW-1:0]      acc_sum [AXES];
   logic [AW-1:0]      mag     [AXES];
   logic [AW-1:0]      sh_mag  [AXES];
   logic [AW-1:0]      cmd_mag [AXES];
   logic [AXES-1:0]    cmd_dir;
   logic [AXES-1:0]    sh_dir;
   logic               sh_full;
   logic [PW-1:0]      pos_q   [AXES];
   logic [AXES-1:0]    pulse_nxt;
   logic               accept, half_end, seg_end, slot_start;
   logic               load, load_sh, load_cmd, to_shadow;

   function automatic logic [AW-1:0] clamp_mag(input logic [MW-1:0] m);
      if (int'(m) > NMAX) return NMAX_A;
      return AW'(m);
   endfunction

   assign cmd_ready  = !sh_full && !abort;
   assign accept     = cmd_valid && cmd_ready;
   assign half_end   = (presc == CW'(HALF_DIV - 1));
   assign seg_end    = (state == RUN) && half_end && (half == HW'(2*NMAX - 1));
   // Odd half-slot ends open the next slot; the SETUP end opens slot 0.
   assign slot_start = half_end && ((state == SETUP) || ((state == RUN) && half[0] && !seg_end));
   assign load_sh    = seg_end && sh_full;
   assign load_cmd   = accept && ((state == IDLE) || seg_end);
   assign load       = !abort && (load_sh || load_cmd);
   assign to_shadow  = accept && !load_cmd;
   assign busy       = (state != IDLE);
   assign dbg_state  = state;

   always_comb begin
      pulse_nxt = pulse;
      for (int i = 0; i < AXES; i++) begin
         acc_sum[i] = acc[i] + mag[i];
         cmd_mag[i] = clamp_mag(cmd[i*NW +: MW]);
         cmd_dir[i] = cmd[i*NW + NW - 1];
      end
      if (abort) begin
         pulse_nxt = '0;
      end else if (slot_start) begin
         for (int i = 0; i < AXES; i++) pulse_nxt[i] = (acc_sum[i] >= NMAX_A);
      end else if ((state == RUN) && half_end && !half[0]) begin
         pulse_nxt = '0;
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (load) state_nxt = SETUP;
            SETUP:   if (half_end) state_nxt = RUN;
            RUN:     if (seg_end) state_nxt = load ? SETUP : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc    <= '0;
         half     <= '0;
         pulse    <= '0;
         dir      <= '0;
         sh_dir   <= '0;
         sh_full  <= 1'b0;
         seg_done <= 1'b0;
         underrun <= 1'b0;
         for (int i = 0; i < AXES; i++) begin
            acc[i]    <= '0;
            mag[i]    <= '0;
            sh_mag[i] <= '0;
         end
      end else begin
         pulse <= pulse_nxt;
         if (abort) begin
            presc    <= '0;
            half     <= '0;
            sh_full  <= 1'b0;
            seg_done <= 1'b0;
            underrun <= 1'b0;
         end else begin
            seg_done <= seg_end;
            underrun <= seg_end && !load;
            if (load || (state == IDLE) || half_end) presc <= '0;
            else                                     presc <= presc + CW'(1);
            if (load || (state == SETUP))            half <= '0;
            else if ((state == RUN) && half_end)     half <= half + HW'(1);
            if (load) begin
               dir <= load_sh ? sh_dir : cmd_dir;
               for (int i = 0; i < AXES; i++) begin
                  acc[i] <= NMAX_A - AW'(1);
                  mag[i] <= load_sh ? sh_mag[i] : cmd_mag[i];
               end
            end else if (slot_start) begin
               for (int i = 0; i < AXES; i++)
                  acc[i] <= (acc_sum[i] >= NMAX_A) ? acc_sum[i] - NMAX_A : acc_sum[i];
            end
            if (load_sh) begin
               sh_full <= 1'b0;
            end else if (to_shadow) begin
               sh_full <= 1'b1;
               sh_dir  <= cmd_dir;
               for (int i = 0; i < AXES; i++) sh_mag[i] <= cmd_mag[i];
            end
         end
      end
   end

   // Position follows the rising edge of each pulse; clear wins over a step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < AXES; i++) pos_q[i] <= '0;
      end else begin
         for (int i = 0; i < AXES; i++) begin
            if (pos_clr)                         pos_q[i] <= '0;
            else if (pulse_nxt[i] && !pulse[i])  pos_q[i] <= dir[i] ? pos_q[i] - PW'(1) : pos_q[i] + PW'(1);
         end
      end
   end

   always_comb begin
      pos = '0;
      for (int i = 0; i < AXES; i++) pos[i*PW +: PW] = pos_q[i];
   end
endmodule

// File: tb/tb_dda_segment_gen.sv
// Bench for dda_segment_gen: a time-indexed segment model checked every cycle,
// directed scenarios with literal counts, then randomized traffic.
module tb_dda_segment_gen;
   localparam int AX  = 2;
   localparam int NWT = 4;
   localparam int NM  = 5;
   localparam int HD  = 2;
   localparam int PWT = 16;
   localparam int L   = (2*NM + 1) * HD;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [AX*NWT-1:0] cmd = '0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              abort = 1'b0;
   logic              pos_clr = 1'b0;
   logic [AX-1:0]     pulse, dir;
   logic [AX*PWT-1:0] pos;
   logic              busy, seg_done, underrun;
   logic [1:0]        dbg_state;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   dda_segment_gen #(.AXES(AX), .NW(NWT), .NMAX(NM), .HALF_DIV(HD), .PW(PWT)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .abort(abort), .pos_clr(pos_clr), .pulse(pulse), .dir(dir), .pos(pos),
      .busy(busy), .seg_done(seg_done), .underrun(underrun), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit             m_active, m_sh_full, m_done, m_und;
   int             m_t;
   int             m_mag [AX];
   int             m_sh_mag [AX];
   logic [AX-1:0]  m_dir, m_sh_dir, m_pulse;
   logic [PWT-1:0] m_pos [AX];

   function automatic int clampv(int v);
      return (v > NM) ? NM : v;
   endfunction

   // Pulse level t cycles after a segment load: slot s emits one pulse each time
   // the running total floor((NM-1 + k*mag)/NM) increases.
   function automatic logic pulse_at(int t, int mg);
      int r, s;
      if (t < HD) return 1'b0;
      r = t - HD;
      s = r / (2*HD);
      if ((r % (2*HD)) >= HD) return 1'b0;
      return ((NM - 1 + (s + 1)*mg) / NM) > ((NM - 1 + s*mg) / NM);
   endfunction

   task automatic m_load_cmd();
      m_t = 0;
      for (int i = 0; i < AX; i++) begin
         m_mag[i] = clampv(int'(cmd[i*NWT +: NWT-1]));
         m_dir[i] = cmd[i*NWT + NWT - 1];
      end
   endtask

   initial forever begin
      bit             acc;
      logic [AX-1:0]  old;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_active = 0; m_sh_full = 0; m_done = 0; m_und = 0; m_t = 0;
         m_dir = '0; m_sh_dir = '0; m_pulse = '0;
         for (int i = 0; i < AX; i++) begin m_mag[i] = 0; m_sh_mag[i] = 0; m_pos[i] = '0; end
      end else begin
         acc = cmd_valid && !m_sh_full && !abort;
         old = m_pulse;
         m_done = 0; m_und = 0;
         if (abort) begin
            m_active = 0; m_sh_full = 0;
         end else if (m_active) begin
            m_t++;
            if (m_t == L) begin
               m_done = 1;
               if (m_sh_full) begin
                  m_t = 0; m_sh_full = 0; m_dir = m_sh_dir;
                  for (int i = 0; i < AX; i++) m_mag[i] = m_sh_mag[i];
               end else if (acc) begin
                  m_load_cmd();
               end else begin
                  m_active = 0; m_und = 1;
               end
            end else if (acc) begin
               m_sh_full = 1;
               for (int i = 0; i < AX; i++) begin
                  m_sh_mag[i] = clampv(int'(cmd[i*NWT +: NWT-1]));
                  m_sh_dir[i] = cmd[i*NWT + NWT - 1];
               end
            end
         end else if (acc) begin
            m_active = 1;
            m_load_cmd();
         end
         for (int i = 0; i < AX; i++) begin
            m_pulse[i] = m_active && pulse_at(m_t, m_mag[i]);
            if (pos_clr)                    m_pos[i] = '0;
            else if (m_pulse[i] && !old[i]) m_pos[i] = m_dir[i] ? m_pos[i] - 1'b1 : m_pos[i] + 1'b1;
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   initial forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
         check("cmd_ready", 32'(cmd_ready), 32'(!m_sh_full && !abort));
         check("pulse",     32'(pulse),     32'(m_pulse));
         check("dir",       32'(dir),       32'(m_dir));
         check("busy",      32'(busy),      32'(m_active));
         check("seg_done",  32'(seg_done),  32'(m_done));
         check("underrun",  32'(underrun),  32'(m_und));
         check("pos0",      32'(pos[0 +: PWT]),   32'(m_pos[0]));
         check("pos1",      32'(pos[PWT +: PWT]), 32'(m_pos[1]));
      end
   end

   // ---------------- event counters ----------------
   int cnt_rise [AX];
   int cnt_busy, cnt_done, cnt_und, cnt_fall;
   logic [AX-1:0] prev_pulse = '0;
   logic prev_busy = 1'b0;

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < AX; i++) if (pulse[i] && !prev_pulse[i]) cnt_rise[i]++;
      if (busy) cnt_busy++;
      if (seg_done) cnt_done++;
      if (underrun) cnt_und++;
      if (prev_busy && !busy) cnt_fall++;
      prev_pulse = pulse;
      prev_busy  = busy;
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < AX; i++) cnt_rise[i] = 0;
      cnt_busy = 0; cnt_done = 0; cnt_und = 0; cnt_fall = 0;
   endtask

   task automatic clr_pos();
      pos_clr = 1'b1; step(1); pos_clr = 1'b0;
   endtask

   task automatic send_cmd(input logic [2:0] m0, input logic d0, input logic [2:0] m1, input logic d1);
      bit got = 0;
      cmd = {d1, m1, d0, m0};
      cmd_valid = 1'b1;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk);
         if (cmd_ready) got = 1;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      checks++;
      if (!got) begin errors++; $display("FAIL send_cmd: got no handshake expected one within 400 cycles"); end
   endtask

   task automatic wait_idle();
      bit idle = 0;
      for (int k = 0; k < 500 && !idle; k++) begin
         @(negedge clk);
         if (!busy) idle = 1;
      end
      checks++;
      if (!idle) begin errors++; $display("FAIL wait_idle: busy stuck 1 expected 0 within 500 cycles"); end
      step(2);
   endtask

   initial begin
      #2;
      check("rst_pulse", 32'(pulse), 0);
      check("rst_busy",  32'(busy), 0);
      check("rst_pos",   32'(pos), 0);
      check("rst_ready", 32'(cmd_ready), 1);
      check("rst_done",  32'({seg_done, underrun}), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      step(2);
      chk_en = 1'b1;

      // single segment: 5 and 2 pulses, 22 busy cycles
      clr_pos(); clear_counts();
      send_cmd(3'd5, 1'b0, 3'd2, 1'b0);
      wait_idle();
      check("s1_rise0", cnt_rise[0], 5);
      check("s1_rise1", cnt_rise[1], 2);
      check("s1_busy",  cnt_busy, 22);
      check("s1_pos0",  32'(pos[0 +: PWT]), 5);
      check("s1_pos1",  32'(pos[PWT +: PWT]), 2);
      check("s1_done",  cnt_done, 1);
      check("s1_und",   cnt_und, 1);

      // back-to-back with direction change
      clr_pos(); clear_counts();
      send_cmd(3'd5, 1'b0, 3'd0, 1'b0);
      send_cmd(3'd3, 1'b1, 3'd0, 1'b0);
      wait_idle();
      check("b2b_pos0", 32'(pos[0 +: PWT]), 2);
      check("b2b_busy", cnt_busy, 44);
      check("b2b_fall", cnt_fall, 1);
      check("b2b_done", cnt_done, 2);
      check("b2b_und",  cnt_und, 1);

      // shadow full: third command waits for the segment end
      clr_pos(); clear_counts();
      send_cmd(3'd2, 1'b0, 3'd1, 1'b0);
      send_cmd(3'd3, 1'b0, 3'd0, 1'b0);
      send_cmd(3'd1, 1'b1, 3'd0, 1'b0);
      wait_idle();
      check("sh_pos0", 32'(pos[0 +: PWT]), 4);
      check("sh_pos1", 32'(pos[PWT +: PWT]), 1);
      check("sh_busy", cnt_busy, 66);
      check("sh_done", cnt_done, 3);
      check("sh_und",  cnt_und, 1);

      // abort in slot 2 with a queued successor
      clr_pos(); clear_counts();
      send_cmd(3'd5, 1'b0, 3'd5, 1'b1);
      send_cmd(3'd2, 1'b0, 3'd2, 1'b0);
      for (int k = 0; k < 200 && cnt_rise[0] < 3; k++) step(1);
      abort = 1'b1; step(1); abort = 1'b0;
      @(negedge clk);
      check("ab_pulse", 32'(pulse), 0);
      check("ab_busy",  32'(busy), 0);
      step(30);
      check("ab_pos0",  32'(pos[0 +: PWT]), 3);
      check("ab_pos1",  32'(pos[PWT +: PWT]), 32'(16'hFFFD));
      check("ab_done",  32'(cnt_done + cnt_und), 0);
      check("ab_rise0", cnt_rise[0], 3);

      // clamp and zero magnitude
      clr_pos(); clear_counts();
      send_cmd(3'd7, 1'b0, 3'd0, 1'b0);
      wait_idle();
      check("cl_rise0", cnt_rise[0], 5);
      check("cl_rise1", cnt_rise[1], 0);
      clear_counts();
      send_cmd(3'd0, 1'b0, 3'd0, 1'b1);
      wait_idle();
      check("z_busy", cnt_busy, 22);
      check("z_rise", cnt_rise[0] + cnt_rise[1], 0);
      check("z_und",  cnt_und, 1);

      // asynchronous reset mid-pulse
      clr_pos();
      send_cmd(3'd5, 1'b0, 3'd5, 1'b0);
      for (int k = 0; k < 100 && !pulse[0]; k++) step(1);
      check("pre_rst_pulse", 32'(pulse[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_pulse", 32'(pulse), 0);
      check("ar_busy",  32'(busy), 0);
      check("ar_pos",   32'(pos), 0);
      check("ar_ready", 32'(cmd_ready), 1);
      @(posedge clk); #1; rst_n = 1'b1;
      step(2);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cmd       = 8'($urandom);
         cmd_valid = ($urandom_range(0, 2) == 0);
         abort     = ($urandom_range(0, 299) == 0);
         pos_clr   = ($urandom_range(0, 249) == 0);
         step(1);
      end
      cmd_valid = 1'b0; abort = 1'b0; pos_clr = 1'b0;
      wait_idle();
      step(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
